// File: rtl/misao_pkg.sv
// Shared types and helpers for the MISAO nibble-memory arbiter.
package misao_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    FINISH = 2'b10
  } state_e;

  typedef enum logic [LEN_W-1:0] {
    SZ_UL   = 2'b00,
    SZ_LK8  = 2'b01,
    SZ_LK16 = 2'b10
  } size_e;

  // Size code 11 is treated as a 4-nibble access.
  function automatic logic [2:0] size_nibbles(input logic [LEN_W-1:0] len);
    case (len)
      SZ_UL:   return 3'd1;
      SZ_LK8:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/misao_mem_arb_if.sv
// Request/grant ports for both requesters plus the nibble-memory side.
interface misao_mem_arb_if
  import misao_pkg::*;
#(
  parameter int unsigned AW = 16
);

  logic              req0, req1;
  logic              we0, we1;
  logic [AW-1:0]     addr0, addr1;
  logic [LEN_W-1:0]  len0, len1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [NIB_W-1:0]  mem_wdata;
  logic [NIB_W-1:0]  mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/misao_rr_arb2.sv
// Two-way round-robin tie-break: a lone request always wins, a tie goes to the port not served last.
module misao_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/misao_mem_arb.sv
// Two-port arbiter that serialises 1/2/4-nibble read/write transactions onto a nibble memory.
module misao_mem_arb
  import misao_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic            clk,
  input  logic            rst,
  misao_mem_arb_if.slave  bus
);

  state_e            state_q, state_d;
  logic [1:0]        grant;
  logic [IDX_W-1:0]  idx_q, last_idx, prev_idx;
  logic              port_q, last_q, we_q;
  logic [AW-1:0]     addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  misao_rr_arb2 u_arb (
    .req   ({bus.req1, bus.req0}),
    .last  (last_q),
    .grant (grant)
  );

  assign last_idx = IDX_W'(size_nibbles(len_q) - 3'd1);
  assign prev_idx = idx_q - IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and outputs; the final read nibble arrives during FINISH and is merged directly.
  always_comb begin
    state_d       = state_q;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rdata     = rdata_q;
    case (state_q)
      IDLE: begin
        bus.gnt0 = grant[0] & ~rst;
        bus.gnt1 = grant[1] & ~rst;
        if (grant != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = we_q;
        bus.mem_addr = addr_q + AW'(idx_q);
        if (we_q) bus.mem_wdata = wdata_q[{idx_q, 2'b00} +: NIB_W];
        if (idx_q == last_idx) state_d = FINISH;
      end
      FINISH: begin
        bus.done0 = ~port_q;
        bus.done1 = port_q;
        if (!we_q) bus.rdata = rdata_q | (DATA_W'(bus.mem_rdata) << {last_idx, 2'b00});
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, access index and read-data assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            port_q  <= grant[1];
            last_q  <= grant[1];
            we_q    <= grant[1] ? bus.we1    : bus.we0;
            addr_q  <= grant[1] ? bus.addr1  : bus.addr0;
            len_q   <= grant[1] ? bus.len1   : bus.len0;
            wdata_q <= grant[1] ? bus.wdata1 : bus.wdata0;
            idx_q   <= '0;
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          idx_q <= (idx_q == last_idx) ? '0 : idx_q + IDX_W'(1);
          if (!we_q && idx_q != '0) rdata_q[{prev_idx, 2'b00} +: NIB_W] <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misao_mem_arb.sv
// Randomised bench for misao_mem_arb with a transaction-timeline reference model and a nibble memory.
module tb_misao_mem_arb;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  misao_mem_arb_if #(.AW(AW)) bus ();

  misao_mem_arb #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [3:0] mem     [0:65535];
  logic [3:0] ref_mem [0:65535];

  // Reference model: t=0 idle, t=1..n access cycles, t=n+1 done cycle.
  int          t = 0;
  int          n = 1;
  bit          m_last = 1'b1;
  bit          m_port = 1'b0;
  bit          m_we   = 1'b0;
  logic [15:0] m_addr, m_wdata, m_rdata_exp, last_rdata;
  int          gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nib_count(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  task automatic drive(input int p, input bit r, input bit we, input logic [15:0] addr,
                       input logic [1:0] len, input logic [15:0] wd);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = addr; bus.len0 = len; bus.wdata0 = wd;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = addr; bus.len1 = len; bus.wdata1 = wd;
    end
  endtask

  // One clock: check this cycle at the falling edge, serve memory, advance past the next rising edge.
  task automatic step();
    bit          e_g0, e_g1, e_d0, e_d1, e_en, e_we, rd_valid;
    logic [15:0] e_addr, a;
    logic [3:0]  e_wd, rd_pend;
    @(negedge clk);
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_wd = '0; rd_pend = '0; rd_valid = 0;
    if (t == 0) begin
      if (bus.req0 || bus.req1) begin
        m_port  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_last  = m_port;
        m_we    = m_port ? bus.we1    : bus.we0;
        m_addr  = m_port ? bus.addr1  : bus.addr0;
        m_wdata = m_port ? bus.wdata1 : bus.wdata0;
        n       = nib_count(m_port ? bus.len1 : bus.len0);
        m_rdata_exp = '0;
        if (!m_we)
          for (int k = 0; k < n; k++) begin
            a = m_addr + 16'(k);
            m_rdata_exp = m_rdata_exp | (16'(ref_mem[a]) << (4 * k));
          end
        e_g0 = !m_port;
        e_g1 = m_port;
        t = 1;
      end
    end else if (t <= n) begin
      e_en   = 1;
      e_we   = m_we;
      e_addr = m_addr + 16'(t - 1);
      if (m_we) begin
        e_wd = m_wdata[4 * (t - 1) +: 4];
        ref_mem[e_addr] = e_wd;
      end
      t++;
    end else begin
      e_d0 = !m_port;
      e_d1 = m_port;
      chk("rdata", 32'(bus.rdata), 32'(m_rdata_exp));
      last_rdata = bus.rdata;
      t = 0;
    end
    chk("gnt0",      32'(bus.gnt0),      32'(e_g0));
    chk("gnt1",      32'(bus.gnt1),      32'(e_g1));
    chk("done0",     32'(bus.done0),     32'(e_d0));
    chk("done1",     32'(bus.done1),     32'(e_d1));
    chk("mem_en",    32'(bus.mem_en),    32'(e_en));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    if (bus.gnt0 || bus.gnt1) gq.push_back(bus.gnt1 ? 1 : 0);
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else begin
        rd_pend  = mem[bus.mem_addr];
        rd_valid = 1;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_rdata = rd_valid ? rd_pend : 4'($urandom);
  endtask

  // Asynchronous reset applied mid-cycle, held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_en",   32'(bus.mem_en),   0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_gnt",      32'(bus.gnt0 | bus.gnt1),   0);
    chk("rst_done",     32'(bus.done0 | bus.done1), 0);
    chk("rst_rdata",    32'(bus.rdata),    0);
    t = 0;
    m_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    bus.mem_rdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 4'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_gnt0",   32'(bus.gnt0),      0);
    chk("init_gnt1",   32'(bus.gnt1),      0);
    chk("init_done",   32'(bus.done0 | bus.done1), 0);
    chk("init_en",     32'(bus.mem_en),    0);
    chk("init_we",     32'(bus.mem_we),    0);
    chk("init_addr",   32'(bus.mem_addr),  0);
    chk("init_wdata",  32'(bus.mem_wdata), 0);
    chk("init_rdata",  32'(bus.rdata),     0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst = 1'b0;

    // Single-nibble read on port 0.
    mem[16'h0010] = 4'hA; ref_mem[16'h0010] = 4'hA;
    drive(0, 1, 0, 16'h0010, 2'b00, '0);
    step();
    bus.req0 = 1'b0;
    repeat (2) step();
    chk("ul_rdata", 32'(last_rdata), 32'h000A);

    // Four-nibble write on port 1.
    drive(1, 1, 1, 16'h1230, 2'b10, 16'hBEEF);
    step();
    bus.req1 = 1'b0;
    repeat (5) step();
    exp_w = 16'hBEEF;
    for (int k = 0; k < 4; k++)
      chk("lk16_mem", 32'(mem[16'h1230 + 16'(k)]), 32'(exp_w[4 * k +: 4]));

    // Both ports held: grants alternate starting with port 0.
    do_reset();
    drive(0, 1, 0, 16'h0100, 2'b01, '0);
    drive(1, 1, 0, 16'h0200, 2'b01, '0);
    gq.delete();
    repeat (12) step();
    chk("alt_count", 32'(gq.size()), 3);
    if (gq.size() >= 3) begin
      chk("alt_first",  32'(gq[0]), 0);
      chk("alt_second", 32'(gq[1]), 1);
      chk("alt_third",  32'(gq[2]), 0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) step();

    // Address wrap at the top of memory.
    mem[16'hFFFF] = 4'h3; ref_mem[16'hFFFF] = 4'h3;
    mem[16'h0000] = 4'h7; ref_mem[16'h0000] = 4'h7;
    drive(0, 1, 0, 16'hFFFF, 2'b01, '0);
    step();
    bus.req0 = 1'b0;
    repeat (3) step();
    chk("wrap_rdata", 32'(last_rdata), 32'h0073);

    // Reset during the second access cycle of a four-nibble write.
    drive(0, 1, 1, 16'h2000, 2'b10, 16'h1234);
    step();
    bus.req0 = 1'b0;
    step();
    chk("pre_rst_en", 32'(bus.mem_en), 1);
    do_reset();
    repeat (3) step();
    drive(1, 1, 0, 16'h0005, 2'b00, '0);
    step();
    bus.req1 = 1'b0;
    repeat (2) step();

    // Size code 11 on port 1 behaves as four nibbles.
    drive(1, 1, 0, 16'h0040, 2'b11, '0);
    step();
    bus.req1 = 1'b0;
    repeat (5) step();

    // Random traffic, operands changing every cycle, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive(0, $urandom_range(0, 2) != 0, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom),
            2'($urandom), 16'($urandom));
      drive(1, $urandom_range(0, 2) != 0, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom),
            2'($urandom), 16'($urandom));
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/misao_mem_arb.md
MISAO_MEM_ARB -- requirements
Module: misao_mem_arb

Interface
REQ-001 Parameter: AW, default 16, memory address width in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset: asynchronous, active-high.
REQ-004 req0/req1  input  1  transaction request (0 = core port, 1 = loader/debug port).
REQ-005 we0/we1  input  1  1 = write, 0 = read.
REQ-006 addr0/addr1  input  AW  base nibble address.
REQ-007 len0/len1  input  2  size code: 00 = 1 nibble (UL), 01 = 2 nibbles (LK8), 10 = 4 nibbles (LK16), 11 = 4 nibbles.
REQ-008 wdata0/wdata1  input  16  write data; nibble k = bits [4k+3:4k].
REQ-009 gnt0/gnt1  output  1  one-cycle pulse: request accepted and operands latched.
REQ-010 done0/done1  output  1  one-cycle pulse: transaction complete.
REQ-011 rdata  output  16  read result, valid while done0 or done1 is high.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-014 mem_addr  output  AW  memory nibble address.
REQ-015 mem_wdata  output  4  memory write nibble.
REQ-016 mem_rdata  input  4  memory read nibble, returned one cycle after the mem_en read cycle.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and FINISH.
REQ-018 In IDLE with any req high, the block SHALL select one winner, latch its we/addr/len/wdata, pulse its gnt and move to ACCESS on the same edge.
REQ-019 If both reqs are high, the winner SHALL be the port not served last; the last-served register resets to 1, so port 0 wins the first tie.
REQ-020 A lone request SHALL be granted regardless of the last-served register; the last-served register SHALL update to the granted port on every grant.
REQ-021 In ACCESS, each cycle SHALL drive mem_en=1, mem_we=latched we and mem_addr=base+idx, where idx counts 0..N-1 (N from len).
REQ-022 mem_addr SHALL wrap modulo 2^AW; an access with base=FFFF and N=2 SHALL address FFFF then 0000.
REQ-023 For writes, mem_wdata SHALL equal latched wdata nibble idx; for reads, mem_wdata SHALL be 0.
REQ-024 When idx==N-1 in ACCESS, the FSM SHALL move to FINISH.
REQ-025 For reads, mem_rdata sampled in the cycle after access k SHALL be stored into rdata nibble k; unaccessed nibbles SHALL read 0.
REQ-026 For writes, rdata SHALL be 0.
REQ-027 In FINISH, the FSM SHALL pulse done for the served port and return to IDLE.
REQ-028 In IDLE and FINISH, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-029 Transaction timeline SHALL be: gnt at cycle 0, ACCESS at cycles 1..N, done at cycle N+1, next grant no earlier than cycle N+2 (one IDLE bubble).
REQ-030 Requests SHALL be sampled only in IDLE; changes to req or operands after gnt SHALL be ignored until the next IDLE.
REQ-031 A port whose req is still high in IDLE after its done SHALL be treated as a new request.
REQ-032 gnt and done SHALL never be high for both ports in the same cycle.

Reset
REQ-033 rst SHALL force IDLE, idx=0, last-served=1, rdata=0, and all of gnt, done and mem_* outputs to 0.
REQ-034 rst asserted mid-transaction SHALL abort it: no done pulse, and no further memory access after reset release until a new grant.

Structure
REQ-035 Package misao_pkg SHALL hold the FSM state enum, the size codes (UL=00, LK8=01, LK16=10) and a size-to-nibble-count function.
REQ-036 Tie-break logic SHALL be a sub-module misao_rr_arb2 (inputs req[1:0] and last; outputs a one-hot grant).

Verification
REQ-037 Read UL, port 0: addr 0x0010, mem[0x0010]=0xA -> gnt0 at t0, one mem_en cycle at 0x0010, done0 at t2, rdata=0x000A.
REQ-038 Write LK16, port 1: addr 0x1230, wdata 0xBEEF -> writes F,E,E,B to 0x1230..0x1233 over 4 cycles, done1 at t5, rdata=0.
REQ-039 Simultaneous LK8 reads on both ports after reset, both reqs held -> port 0 served first, then port 1 after the bubble, then port 0 (alternating).
REQ-040 Wrap: port 0 read LK8 at 0xFFFF, mem[FFFF]=3, mem[0000]=7 -> addresses FFFF then 0000, rdata=0x0073.
REQ-041 Reset mid-transaction: rst during the 2nd ACCESS cycle of an LK16 write -> mem_en=0 immediately, no done pulse, next request granted normally.
REQ-042 len=11 read on port 1 -> behaves as LK16 (4 accesses, done1 at t5).
